// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : post-commit in-order store FIFO draining to data memory, with
//            store-to-load forwarding when STORE_BUFFER_FWD_EN is defined
//            (stall-on-word-match only when it is not).
// Revision : 1.0
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        commit_store_i,
    input  logic [31:0] commit_addr_i,
    input  logic [31:0] commit_data_i,
    input  logic [1:0]  commit_size_i,
    output logic        full_o,
    output logic        empty_o,

    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_data_o,
    output logic [3:0]  dmem_be_o,

    input  logic        ld_valid_i,
    input  logic [31:0] ld_addr_i,
    input  logic [1:0]  ld_size_i,
    output logic        ld_hit_o,
    output logic [31:0] ld_data_o,
    output logic        ld_stall_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Misaligned or size-3 accesses produce an empty mask (no-op write).
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            2'd0:    m = 4'b0001 << off;
            2'd1:    if (!off[0]) m = 4'b0011 << {off[1], 1'b0};
            2'd2:    if (off == 2'b00) m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [29:0]      waddr_q [DEPTH];
    logic [31:0]      wdata_q [DEPTH];
    logic [3:0]       wmask_q [DEPTH];

    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_push  = commit_store_i && !full_o;
    assign w_pop   = !empty_o && dmem_req_ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_pop)  head_d = head_q + PTR_W'(1);
        if (w_push) tail_d = tail_q + PTR_W'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload needs no reset: every reader is qualified by count_q.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            waddr_q[tail_q] <= commit_addr_i[31:2];
            wdata_q[tail_q] <= commit_data_i << {commit_addr_i[1:0], 3'b000};
            wmask_q[tail_q] <= lane_mask(commit_size_i, commit_addr_i[1:0]);
        end
    end

    assign dmem_req_valid_o = !empty_o;
    assign dmem_addr_o      = empty_o ? 32'h0 : {waddr_q[head_q], 2'b00};
    assign dmem_data_o      = empty_o ? 32'h0 : wdata_q[head_q];
    assign dmem_be_o        = empty_o ? 4'h0  : wmask_q[head_q];

    // Scan oldest to youngest so the last match seen is the youngest.
    logic             w_match;
    logic [3:0]       w_hit_mask;
    logic [31:0]      w_hit_data;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        w_match    = 1'b0;
        w_hit_mask = 4'h0;
        w_hit_data = 32'h0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (waddr_q[w_idx] == ld_addr_i[31:2])) begin
                w_match    = 1'b1;
                w_hit_mask = wmask_q[w_idx];
                w_hit_data = wdata_q[w_idx];
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic [3:0] w_ld_mask;
    logic       w_cover;

    assign w_ld_mask  = lane_mask(ld_size_i, ld_addr_i[1:0]);
    assign w_cover    = ((w_hit_mask & w_ld_mask) == w_ld_mask);
    assign ld_hit_o   = ld_valid_i && w_match && w_cover;
    assign ld_stall_o = ld_valid_i && w_match && !w_cover;
    assign ld_data_o  = ld_hit_o ? w_hit_data : 32'h0;
`else
    logic w_unused_ld;

    assign w_unused_ld = ^{ld_size_i, ld_addr_i[1:0], w_hit_mask, w_hit_data};
    assign ld_hit_o    = 1'b0;
    assign ld_data_o   = 32'h0;
    assign ld_stall_o  = ld_valid_i && w_match;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : directed and randomized checks of store_buffer against a
//            queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        commit_store_i;
    logic [31:0] commit_addr_i;
    logic [31:0] commit_data_i;
    logic [1:0]  commit_size_i;
    logic        full_o;
    logic        empty_o;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_data_o;
    logic [3:0]  dmem_be_o;
    logic        ld_valid_i;
    logic [31:0] ld_addr_i;
    logic [1:0]  ld_size_i;
    logic        ld_hit_o;
    logic [31:0] ld_data_o;
    logic        ld_stall_o;

    int n_vec  = 0;
    int n_fail = 0;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .commit_store_i   (commit_store_i),
        .commit_addr_i    (commit_addr_i),
        .commit_data_i    (commit_data_i),
        .commit_size_i    (commit_size_i),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_data_o      (dmem_data_o),
        .dmem_be_o        (dmem_be_o),
        .ld_valid_i       (ld_valid_i),
        .ld_addr_i        (ld_addr_i),
        .ld_size_i        (ld_size_i),
        .ld_hit_o         (ld_hit_o),
        .ld_data_o        (ld_data_o),
        .ld_stall_o       (ld_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending stores, oldest first.
    typedef struct {
        logic [29:0] wa;
        logic [31:0] d;
        logic [3:0]  m;
    } ent_t;

    ent_t mq[$];

    function automatic logic [3:0] model_mask(input logic [1:0] sz, input logic [1:0] off);
        int nb;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        if (nb == 0) return 4'h0;
        if ((int'(off) % nb) != 0) return 4'h0;
        return 4'(((1 << nb) - 1) << int'(off));
    endfunction

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mq.delete();
        end else begin
            int   n0;
            ent_t e;
            n0 = mq.size();
            if (n0 != 0 && dmem_req_ready_i) void'(mq.pop_front());
            if (commit_store_i && n0 < DEPTH) begin
                e.wa = commit_addr_i[31:2];
                e.d  = commit_data_i << (8 * int'(commit_addr_i[1:0]));
                e.m  = model_mask(commit_size_i, commit_addr_i[1:0]);
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk_i) begin
        logic        match, cov, e_hit, e_stall;
        logic [3:0]  ym, lm;
        logic [31:0] yd;
        chk("empty", empty_o, mq.size() == 0);
        chk("full", full_o, mq.size() == DEPTH);
        chk("dmem_valid", dmem_req_valid_o, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("dmem_addr", dmem_addr_o, {mq[0].wa, 2'b00});
            chk("dmem_data", dmem_data_o, mq[0].d);
            chk("dmem_be", dmem_be_o, mq[0].m);
        end
        match = 1'b0;
        ym    = 4'h0;
        yd    = 32'h0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].wa == ld_addr_i[31:2]) begin
                match = 1'b1;
                ym    = mq[i].m;
                yd    = mq[i].d;
                break;
            end
        end
        lm  = model_mask(ld_size_i, ld_addr_i[1:0]);
        cov = ((ym & lm) == lm);
`ifdef STORE_BUFFER_FWD_EN
        e_hit   = ld_valid_i && match && cov;
        e_stall = ld_valid_i && match && !cov;
`else
        e_hit   = 1'b0;
        e_stall = ld_valid_i && match;
`endif
        chk("ld_hit", ld_hit_o, e_hit);
        chk("ld_stall", ld_stall_o, e_stall);
        if (e_hit) chk("ld_data", ld_data_o, yd);
        if (!ld_valid_i) chk("ld_data_idle", ld_data_o, 32'h0);
    end

    task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        commit_store_i = 1'b1;
        commit_addr_i  = a;
        commit_data_i  = d;
        commit_size_i  = s;
        @(posedge clk_i);
        #1;
        commit_store_i = 1'b0;
    endtask

    task automatic drain();
        dmem_req_ready_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (empty_o) break;
            @(posedge clk_i);
            #1;
        end
        chk("drain_done", empty_o, 1'b1);
        dmem_req_ready_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] sz, input bit allow_mis);
        logic [31:0] a;
        a = 32'h1000 + 32'($urandom_range(0, 7) << 2);
        if (allow_mis && $urandom_range(0, 15) == 0) a[1:0] = 2'($urandom);
        else if (sz == 2'd0) a[1:0] = 2'($urandom);
        else if (sz == 2'd1) a[1:0] = {1'($urandom), 1'b0};
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] sz;
        rstn_i           = 1'b0;
        commit_store_i   = 1'b0;
        commit_addr_i    = 32'h0;
        commit_data_i    = 32'h0;
        commit_size_i    = 2'd0;
        dmem_req_ready_i = 1'b0;
        ld_valid_i       = 1'b1;
        ld_addr_i        = 32'h100;
        ld_size_i        = 2'd2;

        // Reset values, with a live load probe.
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_empty", empty_o, 1'b1);
        chk("rst_full", full_o, 1'b0);
        chk("rst_valid", dmem_req_valid_o, 1'b0);
        chk("rst_addr", dmem_addr_o, 32'h0);
        chk("rst_data", dmem_data_o, 32'h0);
        chk("rst_be", dmem_be_o, 4'h0);
        chk("rst_hit", ld_hit_o, 1'b0);
        chk("rst_stall", ld_stall_o, 1'b0);
        chk("rst_lddata", ld_data_o, 32'h0);
        rstn_i     = 1'b1;
        ld_valid_i = 1'b0;

        // Single word store drains on the following cycle.
        dmem_req_ready_i = 1'b1;
        push_st(32'h100, 32'hDEADBEEF, 2'd2);
        chk("sw_valid", dmem_req_valid_o, 1'b1);
        chk("sw_addr", dmem_addr_o, 32'h100);
        chk("sw_be", dmem_be_o, 4'hF);
        chk("sw_data", dmem_data_o, 32'hDEADBEEF);
        @(posedge clk_i);
        #1;
        chk("sw_drained", empty_o, 1'b1);

        // Byte store into the top lane.
        dmem_req_ready_i = 1'b0;
        push_st(32'h203, 32'h000000AB, 2'd0);
        chk("sb_addr", dmem_addr_o, 32'h200);
        chk("sb_be", dmem_be_o, 4'b1000);
        chk("sb_data", dmem_data_o, 32'hAB000000);
        drain();

        // Fill, overflow drops, pointer wrap.
        for (int k = 0; k < 4; k++) push_st(32'h500 + 32'(4 * k), 32'(k + 1), 2'd2);
        chk("fill_full", full_o, 1'b1);
        chk("fill_head", dmem_data_o, 32'h1);
        push_st(32'h510, 32'h55, 2'd2);
        chk("ovf_full", full_o, 1'b1);
        chk("ovf_head", dmem_data_o, 32'h1);
        dmem_req_ready_i = 1'b1;
        push_st(32'h514, 32'h66, 2'd2);
        chk("popfull_full", full_o, 1'b0);
        chk("popfull_head", dmem_data_o, 32'h2);
        dmem_req_ready_i = 1'b0;
        push_st(32'h518, 32'h5, 2'd2);
        chk("refill_full", full_o, 1'b1);
        chk("order_2", dmem_data_o, 32'h2);
        dmem_req_ready_i = 1'b1;
        @(posedge clk_i); #1; chk("order_3", dmem_data_o, 32'h3);
        @(posedge clk_i); #1; chk("order_4", dmem_data_o, 32'h4);
        @(posedge clk_i); #1; chk("order_5", dmem_data_o, 32'h5);
        chk("order_5_addr", dmem_addr_o, 32'h518);
        @(posedge clk_i); #1; chk("order_empty", empty_o, 1'b1);
        dmem_req_ready_i = 1'b0;

        // Backpressure: head held stable.
        push_st(32'h600, 32'hCAFEF00D, 2'd2);
        push_st(32'h606, 32'h00001234, 2'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_addr", dmem_addr_o, 32'h600);
            chk("bp_data", dmem_data_o, 32'hCAFEF00D);
            chk("bp_be", dmem_be_o, 4'hF);
            @(posedge clk_i);
            #1;
        end
        dmem_req_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("half_be", dmem_be_o, 4'b1100);
        chk("half_data", dmem_data_o, 32'h12340000);
        drain();

        // Youngest-wins forwarding and partial overlap.
        push_st(32'h300, 32'h11111111, 2'd2);
        push_st(32'h300, 32'h22222222, 2'd2);
        push_st(32'h401, 32'h0000005A, 2'd0);
        ld_valid_i = 1'b1;
        ld_addr_i  = 32'h300;
        ld_size_i  = 2'd2;
        #1;
`ifdef STORE_BUFFER_FWD_EN
        chk("yw_hit", ld_hit_o, 1'b1);
        chk("yw_data", ld_data_o, 32'h22222222);
        chk("yw_stall", ld_stall_o, 1'b0);
`else
        chk("yw_hit", ld_hit_o, 1'b0);
        chk("yw_stall", ld_stall_o, 1'b1);
`endif
        ld_addr_i = 32'h400;
        #1;
        chk("po_stall", ld_stall_o, 1'b1);
        chk("po_hit", ld_hit_o, 1'b0);
        ld_addr_i = 32'h401;
        ld_size_i = 2'd0;
        #1;
`ifdef STORE_BUFFER_FWD_EN
        chk("lb_hit", ld_hit_o, 1'b1);
        chk("lb_data", ld_data_o, 32'h00005A00);
`else
        chk("lb_stall", ld_stall_o, 1'b1);
`endif
        ld_addr_i = 32'h700;
        ld_size_i = 2'd2;
        #1;
        chk("miss_hit", ld_hit_o, 1'b0);
        chk("miss_stall", ld_stall_o, 1'b0);
        ld_valid_i = 1'b0;
        ld_addr_i  = 32'h300;
        #1;
        chk("idle_hit", ld_hit_o, 1'b0);
        chk("idle_stall", ld_stall_o, 1'b0);
        @(posedge clk_i);
        #1;
        drain();

        // Randomized traffic with one asynchronous reset mid-run.
        for (int i = 0; i < 3000; i++) begin
            sz               = 2'($urandom_range(0, 2));
            commit_store_i   = 1'($urandom);
            commit_size_i    = ($urandom_range(0, 31) == 0) ? 2'd3 : sz;
            commit_addr_i    = rand_addr(sz, 1'b1);
            commit_data_i    = $urandom;
            dmem_req_ready_i = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                                    : ($urandom_range(0, 3) != 0);
            sz               = 2'($urandom_range(0, 2));
            ld_valid_i       = ($urandom_range(0, 3) != 0);
            ld_size_i        = sz;
            ld_addr_i        = rand_addr(sz, 1'b0);
            if (i == 1500) begin
                #2;
                rstn_i = 1'b0;
                @(posedge clk_i);
                #1;
                rstn_i = 1'b1;
            end else begin
                @(posedge clk_i);
                #1;
            end
        end
        commit_store_i = 1'b0;
        ld_valid_i     = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
